// File: rtl/oneton_rd_dispatcher.sv
// rtl/oneton_rd_dispatcher.sv - read-side scheduler fanning one FIFO word out to N lane consumers
//
// Pops one N-lane word from the async FIFO read port, holds it, and offers each
// enabled byte lane to its own consumer over valid/ready. The next word is popped
// only after every enabled lane was accepted or dropped by the idle timeout.
//
// Ports:
//   i_rd_clk, i_rd_rstn      read clock, synchronous active-low reset
//   i_lane_en                lane enable mask, sampled in the POP cycle
//   i_fifo_empty             FIFO read-side empty flag
//   o_fifo_rd_en             FIFO read enable, all ones for one cycle per pop
//   i_fifo_rd_data           FIFO read data, valid the cycle after the pop
//   o_lane_valid/i_lane_ready per-lane handshake
//   o_lane_data              held word, lane k at [k*WIDTH +: WIDTH]
//   o_busy                   high whenever not IDLE
//   o_word_cnt               retired-word counter (wraps)
//   o_drop_flag/i_drop_clr   sticky per-lane drop flags and their clear
module oneton_rd_dispatcher #(
    parameter int WIDTH     = 8,
    parameter int N_READERS = 8,
    parameter int TIMEOUT   = 255,
    parameter int CNT_W     = 16
) (
    input  logic                         i_rd_clk,
    input  logic                         i_rd_rstn,
    input  logic [N_READERS-1:0]         i_lane_en,
    input  logic                         i_fifo_empty,
    output logic [N_READERS-1:0]         o_fifo_rd_en,
    input  logic [N_READERS*WIDTH-1:0]   i_fifo_rd_data,
    output logic [N_READERS-1:0]         o_lane_valid,
    input  logic [N_READERS-1:0]         i_lane_ready,
    output logic [N_READERS*WIDTH-1:0]   o_lane_data,
    output logic                         o_busy,
    output logic [CNT_W-1:0]             o_word_cnt,
    output logic [N_READERS-1:0]         o_drop_flag,
    input  logic                         i_drop_clr
);

    // A zero TIMEOUT still needs a one-bit counter to keep the vector legal.
    localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_POP  = 2'd1,
        S_LOAD = 2'd2,
        S_DISP = 2'd3
    } state_t;

    state_t                       state_q, state_d;
    logic [N_READERS*WIDTH-1:0]   data_q, data_d;
    logic [N_READERS-1:0]         pending_q, pending_d;
    logic [N_READERS-1:0]         en_q, en_d;
    logic [TO_W-1:0]              to_cnt_q, to_cnt_d;
    logic [CNT_W-1:0]             word_cnt_q, word_cnt_d;
    logic [N_READERS-1:0]         drop_q, drop_d;

    logic                         start_ok;
    logic [N_READERS-1:0]         hs;
    logic [N_READERS-1:0]         pend_left;
    logic [N_READERS-1:0]         drop_set;
    logic [TO_W-1:0]              to_inc;
    logic                         timeout_hit;

    always_ff @(posedge i_rd_clk) begin
        if (!i_rd_rstn) begin
            state_q    <= S_IDLE;
            data_q     <= '0;
            pending_q  <= '0;
            en_q       <= '0;
            to_cnt_q   <= '0;
            word_cnt_q <= '0;
            drop_q     <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            pending_q  <= pending_d;
            en_q       <= en_d;
            to_cnt_q   <= to_cnt_d;
            word_cnt_q <= word_cnt_d;
            drop_q     <= drop_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        pending_d   = pending_q;
        en_d        = en_q;
        to_cnt_d    = to_cnt_q;
        word_cnt_d  = word_cnt_q;
        drop_set    = '0;
        pend_left   = pending_q;
        start_ok    = !i_fifo_empty && (|i_lane_en);
        hs          = (state_q == S_DISP) ? (pending_q & i_lane_ready) : '0;
        to_inc      = to_cnt_q + 1'b1;
        // Only a cycle with no handshake at all can expire the word.
        timeout_hit = (TIMEOUT != 0) && (hs == '0) && (to_inc == TO_W'(TIMEOUT));

        case (state_q)
            S_IDLE: begin
                if (start_ok) begin
                    state_d = S_POP;
                end
            end
            S_POP: begin
                en_d    = i_lane_en;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                data_d    = i_fifo_rd_data;
                pending_d = en_q;
                to_cnt_d  = '0;
                state_d   = S_DISP;
            end
            default: begin
                pend_left = pending_q & ~hs;
                to_cnt_d  = (hs != '0) ? '0 : to_inc;
                if (timeout_hit && (pend_left != '0)) begin
                    drop_set  = pend_left;
                    pend_left = '0;
                end
                pending_d = pend_left;
                // Retire decision sees this cycle's handshakes and any drop.
                if (pend_left == '0) begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    state_d    = start_ok ? S_POP : S_IDLE;
                end
            end
        endcase

        // Clear first, then OR in new drops so a same-cycle drop survives.
        drop_d = (i_drop_clr ? '0 : drop_q) | drop_set;
    end

    always_comb begin
        o_fifo_rd_en = (state_q == S_POP) ? '1 : '0;
        o_lane_valid = (state_q == S_DISP) ? pending_q : '0;
        o_busy       = (state_q != S_IDLE);
        o_lane_data  = data_q;
        o_word_cnt   = word_cnt_q;
        o_drop_flag  = drop_q;
    end

endmodule

// File: tb/tb_oneton_rd_dispatcher.sv
// tb/tb_oneton_rd_dispatcher.sv - directed self-checking bench for oneton_rd_dispatcher
module tb_oneton_rd_dispatcher;

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  lane_en;
    logic        fifo_empty;
    logic [63:0] rd_data;
    logic [7:0]  ready;
    logic        drop_clr;

    logic [7:0]  rd_en_a, valid_a, drop_a;
    logic [63:0] data_a;
    logic        busy_a;
    logic [15:0] cnt_a;

    logic [7:0]  rd_en_b, valid_b, drop_b;
    logic [63:0] data_b;
    logic        busy_b;
    logic [1:0]  cnt_b;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          pops = 0;
    logic        sel_b = 1'b0;
    logic [63:0] q[$];
    int          pulse_cyc[$];

    always #5 clk = ~clk;

    oneton_rd_dispatcher #(.WIDTH(8), .N_READERS(8), .TIMEOUT(255), .CNT_W(16)) dut_a (
        .i_rd_clk(clk), .i_rd_rstn(rstn), .i_lane_en(lane_en), .i_fifo_empty(fifo_empty),
        .o_fifo_rd_en(rd_en_a), .i_fifo_rd_data(rd_data), .o_lane_valid(valid_a),
        .i_lane_ready(ready), .o_lane_data(data_a), .o_busy(busy_a), .o_word_cnt(cnt_a),
        .o_drop_flag(drop_a), .i_drop_clr(drop_clr)
    );

    oneton_rd_dispatcher #(.WIDTH(8), .N_READERS(8), .TIMEOUT(4), .CNT_W(2)) dut_b (
        .i_rd_clk(clk), .i_rd_rstn(rstn), .i_lane_en(lane_en), .i_fifo_empty(fifo_empty),
        .o_fifo_rd_en(rd_en_b), .i_fifo_rd_data(rd_data), .o_lane_valid(valid_b),
        .i_lane_ready(ready), .o_lane_data(data_b), .o_busy(busy_b), .o_word_cnt(cnt_b),
        .o_drop_flag(drop_b), .i_drop_clr(drop_clr)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock; emulates a FIFO whose pop takes effect at the edge ending the POP cycle.
    task automatic step();
        logic pop;
        pop = sel_b ? rd_en_b[0] : rd_en_a[0];
        @(posedge clk);
        #1;
        cyc++;
        if (pop) begin
            pops++;
            if (q.size() > 0) rd_data = q.pop_front();
        end
        fifo_empty = (q.size() == 0);
        if ((sel_b ? rd_en_b : rd_en_a) == 8'hFF) pulse_cyc.push_back(cyc);
    endtask

    task automatic push(input logic [63:0] w);
        q.push_back(w);
        fifo_empty = 1'b0;
    endtask

    initial begin
        logic [63:0] w0;
        int          pops_before;
        w0       = 64'h0807060504030201;
        rstn     = 1'b0;
        lane_en  = 8'hFF;
        rd_data  = '0;
        ready    = 8'hFF;
        drop_clr = 1'b0;
        fifo_empty = 1'b1;

        // 1: reset with a non-empty FIFO
        push(w0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_outs", {rd_en_a, valid_a, busy_a, drop_a, cnt_a}, '0);
            check("rst_data", data_a, '0);
        end
        rstn = 1'b1;
        step();
        check("first_rd_en", {56'd0, rd_en_a}, 64'hFF);
        check("first_busy", {63'd0, busy_a}, 64'd1);

        // 2: single word, all lanes ready
        step();
        check("load_valid", {48'd0, rd_en_a, valid_a}, 64'd0);
        step();
        check("disp_valid", {56'd0, valid_a}, 64'hFF);
        for (int k = 0; k < 8; k++) check("lane_data", {56'd0, data_a[k*8 +: 8]}, 64'(k + 1));
        step();
        check("w1_valid_off", {56'd0, valid_a}, 64'd0);
        check("w1_busy", {63'd0, busy_a}, 64'd0);
        check("w1_cnt", {48'd0, cnt_a}, 64'd1);
        check("w1_pops", 64'(pops), 64'd1);

        // 3: lane 0 stalls for five DISP cycles
        ready = 8'hFE;
        push(w0);
        step();
        step();
        step();
        check("stall_c0", {56'd0, valid_a}, 64'hFF);
        step();
        for (int i = 1; i <= 5; i++) begin
            check("stall_valid", {56'd0, valid_a}, 64'h01);
            check("stall_lane0", {56'd0, data_a[7:0]}, 64'h01);
            check("stall_no_rd", {56'd0, rd_en_a}, 64'd0);
            if (i == 5) ready = 8'hFF;
            step();
        end
        check("stall_cnt", {48'd0, cnt_a}, 64'd2);
        check("stall_idle", {63'd0, busy_a}, 64'd0);

        // 4: timeout drop on the TIMEOUT=4 instance, then drop clear behaviour
        rstn = 1'b0;
        q.delete();
        fifo_empty = 1'b1;
        step();
        rstn  = 1'b1;
        sel_b = 1'b1;
        check("rst2_b", {cnt_b, drop_b, busy_b}, '0);
        ready = 8'hF7;
        push(64'h1111111111111111);
        push(64'h2222222222222222);
        step();
        step();
        step();
        check("to_c0", {56'd0, valid_b}, 64'hFF);
        step();
        for (int i = 1; i <= 4; i++) begin
            check("to_valid", {56'd0, valid_b}, 64'h08);
            check("to_nodrop", {56'd0, drop_b}, 64'd0);
            step();
        end
        check("to_drop", {56'd0, drop_b}, 64'h08);
        check("to_cnt", {62'd0, cnt_b}, 64'd1);
        check("to_repop", {56'd0, rd_en_b}, 64'hFF);
        ready = 8'hEF;
        step();
        step();
        check("to2_c0", {56'd0, valid_b}, 64'hFF);
        step();
        for (int i = 1; i <= 4; i++) begin
            check("to2_valid", {56'd0, valid_b}, 64'h10);
            if (i == 4) drop_clr = 1'b1;
            step();
        end
        drop_clr = 1'b0;
        check("set_wins", {56'd0, drop_b}, 64'h10);
        check("to2_cnt", {62'd0, cnt_b}, 64'd2);
        check("to2_idle", {63'd0, busy_b}, 64'd0);
        drop_clr = 1'b1;
        step();
        drop_clr = 1'b0;
        check("drop_clr", {56'd0, drop_b}, 64'd0);

        // 5: partial lane mask, then zero mask
        rstn = 1'b0;
        step();
        rstn    = 1'b1;
        sel_b   = 1'b0;
        lane_en = 8'h0F;
        ready   = 8'hFF;
        push(w0);
        step();
        step();
        step();
        check("mask_valid", {56'd0, valid_a}, 64'h0F);
        step();
        check("mask_cnt", {48'd0, cnt_a}, 64'd1);
        check("mask_idle", {63'd0, busy_a}, 64'd0);
        lane_en = 8'h00;
        push(w0);
        pops_before = pops;
        for (int i = 0; i < 5; i++) begin
            step();
            check("zero_en", {55'd0, busy_a, rd_en_a}, 64'd0);
        end
        check("zero_en_pops", 64'(pops), 64'(pops_before));

        // 6: back-to-back words, counter wrap on CNT_W=2
        q.delete();
        fifo_empty = 1'b1;
        rstn = 1'b0;
        step();
        rstn    = 1'b1;
        lane_en = 8'hFF;
        for (int i = 0; i < 5; i++) push(64'(i + 1) * 64'h0101010101010101);
        pulse_cyc.delete();
        for (int i = 0; i < 40; i++) begin
            step();
            if (pulse_cyc.size() == 5 && !busy_a) break;
        end
        check("b2b_pulses", 64'(pulse_cyc.size()), 64'd5);
        for (int i = 1; i < pulse_cyc.size(); i++)
            check("b2b_gap", 64'(pulse_cyc[i] - pulse_cyc[i-1]), 64'd3);
        check("b2b_cnt", {48'd0, cnt_a}, 64'd5);
        check("b2b_wrap", {62'd0, cnt_b}, 64'd1);
        check("b2b_idle", {63'd0, busy_a}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
